// File: rtl/hazard_sched_pkg.sv
// Shared Tuse/Tnew encodings, default MDU latencies and the pipeline slot type.
// The control unit uses the same encodings when it decodes an instruction.
package hazard_sched_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] tnew;
  } slot_t;

  // A slot with wa==0 never matches because src==0 is rejected first.
  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input slot_t e, input slot_t m);
    logic hit_e;
    logic hit_m;
    hit_e = (src == e.wa) && (tuse < e.tnew);
    hit_m = (src == m.wa) && (tuse < m.tnew);
    return (src != 5'd0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
  endfunction

endpackage

// File: rtl/hazard_sched_if.sv
// Decode-stage to scheduler signal bundle: D-stage operand/destination info in, stall and MDU status out.
interface hazard_sched_if #(
  parameter int CNT_W = 4
);
  logic [4:0]       d_rs;
  logic [4:0]       d_rt;
  logic [1:0]       d_tuse_rs;
  logic [1:0]       d_tuse_rt;
  logic [4:0]       d_wa;
  logic [1:0]       d_tnew;
  logic             d_md;
  logic             d_md_start;
  logic             d_md_div;
  logic             stall;
  logic             md_busy;
  logic [CNT_W-1:0] md_cnt;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew, d_md, d_md_start, d_md_div,
    input  stall, md_busy, md_cnt
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew, d_md, d_md_start, d_md_div,
    output stall, md_busy, md_cnt
  );
endinterface

// File: rtl/hazard_sched_md_busy_cnt.sv
// MDU busy counter: loads the mult/div latency when an MDU op sits in E, else saturating decrement.
module md_busy_cnt #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A new start overrides whatever is left of the previous operation.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = start || (cnt_q != '0);
endmodule

// File: rtl/hazard_sched.sv
// hazard_sched: decode-stage stall generator covering E/M operand hazards and the MDU busy window.
// The MDU interlock is built only when HAZARD_SCHED_MDU_EN is defined; otherwise MDU inputs are ignored.
module hazard_sched
  import hazard_sched_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic          clk,
  input  logic          reset,
  hazard_sched_if.slave dif
);
  if ((MULT_LAT >= (1 << CNT_W)) || (DIV_LAT >= (1 << CNT_W))) begin : g_lat_chk
    $error("hazard_sched: CNT_W too narrow for MDU latency");
  end

  slot_t e_q;
  slot_t e_d;
  slot_t m_q;
  slot_t m_d;
  logic  hz_rs;
  logic  hz_rt;
  logic  hz_md;
  logic  stall;

  always_comb begin
    hz_rs = src_hazard(dif.d_rs, dif.d_tuse_rs, e_q, m_q);
    hz_rt = src_hazard(dif.d_rt, dif.d_tuse_rt, e_q, m_q);
    stall = hz_rs || hz_rt || hz_md;
    // A stalled D injects a bubble into E while D itself is held upstream.
    e_d = '0;
    if (!stall) begin
      e_d.wa   = dif.d_wa;
      e_d.tnew = dif.d_tnew;
    end
    m_d.wa   = e_q.wa;
    m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
    end
  end

  assign dif.stall = stall;

`ifdef HAZARD_SCHED_MDU_EN
  logic             e_md_start_q;
  logic             e_md_start_d;
  logic             e_md_div_q;
  logic             e_md_div_d;
  logic             md_busy;
  logic [CNT_W-1:0] md_cnt;

  always_comb begin
    e_md_start_d = dif.d_md_start && !stall;
    e_md_div_d   = dif.d_md_div && !stall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
    end else begin
      e_md_start_q <= e_md_start_d;
      e_md_div_q   <= e_md_div_d;
    end
  end

  md_busy_cnt #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_cnt (
    .clk    (clk),
    .reset  (reset),
    .start  (e_md_start_q),
    .is_div (e_md_div_q),
    .cnt    (md_cnt),
    .busy   (md_busy)
  );

  assign hz_md       = dif.d_md && md_busy;
  assign dif.md_busy = md_busy;
  assign dif.md_cnt  = md_cnt;
`else
  logic unused_md;
  assign unused_md   = ^{dif.d_md, dif.d_md_start, dif.d_md_div};
  assign hz_md       = 1'b0;
  assign dif.md_busy = 1'b0;
  assign dif.md_cnt  = {CNT_W{1'b0}};
`endif
endmodule

// File: doc/hazard_sched.md
# hazard_sched

Pipeline scheduler for the five-stage core's decode stage. It tracks the destination register and result-readiness (Tnew) of the instructions in the E and M stages. It also runs a busy counter for the multi-cycle multiply/divide unit. From these it raises a single `stall` that freezes F/D and injects a bubble into E whenever the instruction in D would read an operand before it can be forwarded, or would touch the MDU while it is busy.

## Interface
Parameters:
- `MULT_LAT`, 5, cycles the MDU is busy after a mult/multu enters E
- `DIV_LAT`, 10, cycles the MDU is busy after a div/divu enters E
- `CNT_W`, 4, busy-counter width; must hold `max(MULT_LAT, DIV_LAT)`

Ports:
- `clk`  in  1  single core clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low; `reset==0` clears all state immediately
- `d_rs`, `d_rt`  in  5 each  source registers of the instruction in D
- `d_tuse_rs`, `d_tuse_rt`  in  2 each  cycles from D until the operand is consumed; 3 = operand not read
- `d_wa`  in  5  destination register of D; 0 = no write
- `d_tnew`  in  2  cycles after entering E until the result is forwardable (ALU=1, load=2, link=0)
- `d_md`  in  1  D reads or writes the MDU (mult/div/mfhi/mflo/mthi/mtlo)
- `d_md_start`  in  1  D is mult/multu/div/divu
- `d_md_div`  in  1  qualifies `d_md_start`: 1 = divide
- `stall`  out  1  freeze PC and the D register, bubble into E
- `md_busy`  out  1  MDU computing or being started this cycle
- `md_cnt`  out  `CNT_W`  remaining busy cycles (debug/verification)

## Operation
- State: E slot {`e_wa`, `e_tnew`, `e_md_start`, `e_md_div`}, M slot {`m_wa`, `m_tnew`}, counter `md_cnt`.
- Slot advance each cycle:
  - Not stalled: E slot loads the D fields.
  - Stalled: E slot loads a bubble (wa=0, tnew=0, md_start=0).
  - M slot always loads from E, with `m_tnew = (e_tnew==0) ? 0 : e_tnew-1`.
  - W needs no slot; its results are always forwardable.
- Operand hazard for source `s` in {rs, rt}:
  - `hz_s = s!=0 && tuse_s!=3 && ((s==e_wa && tuse_s < e_tnew) || (s==m_wa && tuse_s < m_tnew))`.
  - A slot with wa=0 never matches.
- MDU:
  - When `e_md_start==1`, `md_cnt` loads `MULT_LAT` or `DIV_LAT` per `e_md_div`.
  - Otherwise it decrements to 0 and saturates at 0.
  - `md_busy = e_md_start || md_cnt!=0`.
  - `hz_md = d_md && md_busy`.
- `stall = hz_rs || hz_rt || hz_md`.
- Reset values: both slots zero, `md_cnt=0`, so `stall=0` and `md_busy=0`.

## Timing
- `stall` is combinational from D inputs and registered state, valid in the same cycle. There is no added latency.
- A stall lasts exactly until the producer's Tnew drops to the consumer's Tuse:
  - load→ALU-use with Tuse 0: 2-cycle stall if the load is in E, 1 cycle if it is in M.
  - ALU→branch with Tuse 0: 1-cycle stall.
- MDU timing for a mult entering E at cycle t:
  - `md_busy=1` for cycles t .. t+`MULT_LAT`.
  - The counter reads `MULT_LAT` at t+1 and 0 at t+1+`MULT_LAT`.
- A back-to-back mult in D while the first is in E stalls, because `e_md_start` counts as busy.
- Simultaneous load into E and counter at 1: the load wins.
- Reset mid-stall or mid-MDU operation clears everything asynchronously. The first cycle after release behaves as power-on.

## Configuration
- `HAZARD_SCHED_MDU_EN` defined: counter, `md_busy`, and `hz_md` are implemented as described.
- `HAZARD_SCHED_MDU_EN` undefined:
  - The counter and `e_md_*` fields are removed.
  - `md_busy` and `md_cnt` are tied to 0 and `hz_md=0`.
  - MDU inputs are ignored.

## Structure
- The shared macros header carries the Tuse/Tnew encodings (`TUSE_NONE=2'd3`, `TNEW_ALU`, `TNEW_LOAD`) and the default latencies. CU consumes the same encodings.
- One sub-module, `md_busy_cnt`, holds the counter, load, and saturating decrement. The hazard compare and slots stay in the top module.

## Test plan
- Reset low with arbitrary inputs → `stall=0`, `md_busy=0`, `md_cnt=0`.
- lw $8 (tnew 2) issued, then D add reading rs=$8 with tuse 1 → `stall=1` for 1 cycle, then 0.
- lw $8, then D beq reading rs=$8 with tuse 0 → `stall=1` for 2 cycles.
- D reads $0 while an E slot has wa=0 and tnew=2 → `stall=0`.
- div enters E, then D is mflo → `stall=1` for 11 cycles (t..t+10); `md_cnt` counts 10→0; `stall` drops when `md_cnt` reaches 0.
- Reset asserted with `md_cnt=7` → counter reads 0 immediately.
- Macro undefined: div, then mflo → `stall=0`.
